uc_multiciclo: RTL and testbench
================================

Name: uc_multiciclo

Overview:
- Multicycle control unit for the RV32I subset datapath. Extends the existing fetch/IR-load sequencing to decode and execute, with separate paths for R-type, I-type ALU, load, store, BEQ/BNE and JAL.
- Pure Moore FSM: every datapath enable and mux select is decoded from the current state only.
- Sits beside the datapath top level. It drives PC, IR, A/B, ALUOut, MDR, register file and data-memory controls, and reads opcode/funct3 from IR and the ALU zero flag.

Parameters:
- MEM_WAIT, 1, data-memory read wait cycles between the MEM_READ state and MDR capture (0..15).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- zero  in  1  ALU result == 0
- estado  out  7  current state encoding (debug)
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if branch taken
- BranchNe  out  1  1 = branch taken when zero==0 (BNE); 0 = taken when zero==1 (BEQ)
- LoadIR  out  1  IR load
- LoadPCold  out  1  capture the current PC into the PCold register
- MemRead  out  1  data-memory read
- MemWrite  out  1  data-memory write
- LoadMDR  out  1  MDR load
- LoadAB  out  1  A/B register load
- LoadALUOut  out  1  ALUOut load
- RegWrite  out  1  register-file write
- ALUSrcA  out  2  0=PC, 1=A, 2=PCold
- ALUSrcB  out  2  0=B, 1=const 4, 2=imm
- ALUOp  out  2  0=add, 1=sub, 2=funct-decoded
- PCSource  out  2  0=ALU result, 1=ALUOut
- MemToReg  out  2  0=ALUOut, 1=MDR, 2=PC
- erro  out  1  illegal-opcode halt flag

Behaviour:
- reset low → state RST immediately, wait counter 0. This holds even mid-instruction: any pending write is dropped.
- In RST: all enables 0, all selects 0, erro 0, estado=0.
- The state register updates on the rising edge of clock while reset is high.
- Outputs not listed for a state are 0.
- States (estado value), outputs and next state:
  - RST(0): → BUSCA.
  - BUSCA(1): LoadPCold=1, PCWrite=1, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0 (PC←PC+4). → SALVA_INSTR.
  - SALVA_INSTR(2): LoadIR=1 (synchronous instruction memory output is valid this cycle). → DECODE.
  - DECODE(3): LoadAB=1, LoadALUOut=1, ALUSrcA=2, ALUSrcB=2, ALUOp=0 (ALUOut←PCold+imm, branch/jump target).
    - Dispatch on opcode: 0110011→EXEC_R; 0010011→EXEC_I; 0000011 or 0100011→ADDR; 1100011→BRANCH; 1101111→JAL; other→ERRO.
  - EXEC_R(4): ALUSrcA=1, ALUSrcB=0, ALUOp=2, LoadALUOut=1. → WB_ALU.
  - EXEC_I(5): ALUSrcA=1, ALUSrcB=2, ALUOp=2, LoadALUOut=1. → WB_ALU.
  - WB_ALU(6): RegWrite=1, MemToReg=0. → BUSCA.
  - ADDR(7): ALUSrcA=1, ALUSrcB=2, ALUOp=0, LoadALUOut=1. → MEM_READ if opcode=0000011, else MEM_WRITE.
  - MEM_READ(8): MemRead=1, counter←0. → WB_LOAD if MEM_WAIT=0, else MEM_WAIT_S.
  - MEM_WAIT_S(9): MemRead=1, counter++. When counter reaches MEM_WAIT-1: LoadMDR=1, → WB_LOAD.
    - With MEM_WAIT=0, MEM_READ asserts LoadMDR itself.
  - WB_LOAD(10): RegWrite=1, MemToReg=1. → BUSCA.
  - MEM_WRITE(11): MemWrite=1 for exactly one cycle. → BUSCA.
  - BRANCH(12): ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1, BranchNe=funct3[0].
    - funct3 other than 000/001 → ERRO instead, with PCWriteCond=0.
    - → BUSCA.
  - JAL(13): RegWrite=1, MemToReg=2 (rd←PC, already +4), PCWrite=1, PCSource=1. → BUSCA.
  - ERRO(127): erro=1, all enables 0. Stays in ERRO until reset.
- Latency per instruction, BUSCA to next BUSCA:
  - R/I: 5 cycles.
  - Load: 6+MEM_WAIT cycles.
  - Store: 5 cycles.
  - Branch and JAL: 4 cycles.
- MemRead and MemWrite are never both 1. RegWrite is never 1 in the same cycle as PCWriteCond.
- Wait counter is 4 bits. MEM_WAIT above 15 is a compile-time error via assertion.

Decomposition:
- Package uc_pkg holds:
  - the state enum (7-bit, values above);
  - opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL);
  - ALUSrcA, ALUSrcB, ALUOp, PCSource and MemToReg encodings.
- Sub-module uc_wait_cnt: loadable 4-bit down-counter with a done flag, used for the memory wait.

Test Plan:
- Release reset after 3 cycles with opcode=0110011 → estado sequence 0,1,2,3,4,6,1; PCWrite=1 only in BUSCA; RegWrite=1 only in state 6.
- Load, opcode=0000011, MEM_WAIT=2 → states 3,7,8,9,9,10,1; LoadMDR=1 exactly on the second state-9 cycle; total 8 cycles BUSCA-to-BUSCA.
- BNE, opcode=1100011, funct3=001, zero=0 → in state 12: PCWriteCond=1, BranchNe=1, PCSource=1; next state 1.
- Same with funct3=011 → ERRO (127), erro=1. erro stays 1 for 20 cycles, then reset low for 1 cycle → estado=0, erro=0.
- Store with MEM_WAIT=0 and a load → MemWrite pulses exactly 1 cycle; the load path skips state 9 with LoadMDR=1 in state 8.
- Assert reset low asynchronously mid-MEM_WAIT_S (between clock edges) → estado=0 and all enables 0 before the next rising edge; execution restarts from BUSCA after release.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared definitions for the RV32I multicycle control unit: state encoding,
// opcode values and the datapath mux/ALU select encodings.
// Pure constants and types; no logic, no latency.
package uc_pkg;

  // State values double as the debug 'estado' output, so they are fixed.
  typedef enum logic [6:0] {
    ST_RST         = 7'd0,
    ST_BUSCA       = 7'd1,
    ST_SALVA_INSTR = 7'd2,
    ST_DECODE      = 7'd3,
    ST_EXEC_R      = 7'd4,
    ST_EXEC_I      = 7'd5,
    ST_WB_ALU      = 7'd6,
    ST_ADDR        = 7'd7,
    ST_MEM_READ    = 7'd8,
    ST_MEM_WAIT_S  = 7'd9,
    ST_WB_LOAD     = 7'd10,
    ST_MEM_WRITE   = 7'd11,
    ST_BRANCH      = 7'd12,
    ST_JAL         = 7'd13,
    ST_ERRO        = 7'd127
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] SRCA_PC     = 2'd0;
  localparam logic [1:0] SRCA_A      = 2'd1;
  localparam logic [1:0] SRCA_PCOLD  = 2'd2;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_4      = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;

  localparam logic [1:0] M2R_ALUOUT  = 2'd0;
  localparam logic [1:0] M2R_MDR     = 2'd1;
  localparam logic [1:0] M2R_PC      = 2'd2;

  localparam int unsigned WAIT_CNT_W = 4;

  // Only BEQ (000) and BNE (001) are implemented among the branches.
  function automatic logic branch_f3_ok(input logic [2:0] f3);
    return (f3[2:1] == 2'b00);
  endfunction

endpackage

// File: rtl/uc_wait_cnt.sv
// Loadable down-counter timing the data-memory read wait.
// Latency: load/decrement take effect on the next clock; done_o is registered state.
// Backpressure: none; the FSM decides when to load and when to count.
// Ports: clk_i, rst_ni (async, active-low), load_i/load_val_i, dec_i, done_o.
module uc_wait_cnt
  import uc_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic [WAIT_CNT_W-1:0] load_val_i,
  input  logic                  dec_i,
  output logic                  done_o
);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/uc_multiciclo.sv
// Moore control FSM for the RV32I multicycle datapath (fetch, decode, execute).
// Latency: R/I/store 5 cycles, load 6+MEM_WAIT, branch/JAL 4 (BUSCA to BUSCA).
// Backpressure: none; memory reads stall a fixed MEM_WAIT cycles in MEM_WAIT_S.
// Ports: clock/reset (async, active-low); opcode/funct3/zero from datapath;
//        estado (debug), PC/IR/AB/ALUOut/MDR/regfile/memory enables and mux selects; erro.
module uc_multiciclo
  import uc_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  output logic [6:0] estado,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNe,
  output logic       LoadIR,
  output logic       LoadPCold,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       LoadMDR,
  output logic       LoadAB,
  output logic       LoadALUOut,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [1:0] MemToReg,
  output logic       erro
);

  if (MEM_WAIT > 15) begin : g_bad_mem_wait
    $error("uc_multiciclo: MEM_WAIT must be in 0..15");
  end

  // The counter is preloaded with MEM_WAIT-1 so it reaches zero on the last wait cycle.
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);

  state_e state_q, state_d;
  logic   cnt_load, cnt_dec, cnt_done;

  // The branch decision is taken by the datapath from zero/BranchNe/PCWriteCond.
  logic   unused_zero;
  assign unused_zero = zero;

  uc_wait_cnt u_wait_cnt (
    .clk_i      (clock),
    .rst_ni     (reset),
    .load_i     (cnt_load),
    .load_val_i (WAIT_LOAD),
    .dec_i      (cnt_dec),
    .done_o     (cnt_done)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNe    = 1'b0;
    LoadIR      = 1'b0;
    LoadPCold   = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    LoadMDR     = 1'b0;
    LoadAB      = 1'b0;
    LoadALUOut  = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_B;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    MemToReg    = M2R_ALUOUT;
    erro        = 1'b0;

    unique case (state_q)
      ST_RST: state_d = ST_BUSCA;

      ST_BUSCA: begin
        LoadPCold = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_4;
        ALUOp     = ALUOP_ADD;
        PCSource  = PCSRC_ALU;
        state_d   = ST_SALVA_INSTR;
      end

      ST_SALVA_INSTR: begin
        LoadIR  = 1'b1;
        state_d = ST_DECODE;
      end

      // Branch/jump target is computed speculatively from PCold while A/B load.
      ST_DECODE: begin
        LoadAB     = 1'b1;
        LoadALUOut = 1'b1;
        ALUSrcA    = SRCA_PCOLD;
        ALUSrcB    = SRCB_IMM;
        ALUOp      = ALUOP_ADD;
        unique case (opcode)
          OP_R:              state_d = ST_EXEC_R;
          OP_I:              state_d = ST_EXEC_I;
          OP_LOAD, OP_STORE: state_d = ST_ADDR;
          OP_BRANCH:         state_d = ST_BRANCH;
          OP_JAL:            state_d = ST_JAL;
          default:           state_d = ST_ERRO;
        endcase
      end

      ST_EXEC_R: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_B;
        ALUOp      = ALUOP_FUNCT;
        LoadALUOut = 1'b1;
        state_d    = ST_WB_ALU;
      end

      ST_EXEC_I: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        ALUOp      = ALUOP_FUNCT;
        LoadALUOut = 1'b1;
        state_d    = ST_WB_ALU;
      end

      ST_WB_ALU: begin
        RegWrite = 1'b1;
        MemToReg = M2R_ALUOUT;
        state_d  = ST_BUSCA;
      end

      ST_ADDR: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        ALUOp      = ALUOP_ADD;
        LoadALUOut = 1'b1;
        state_d    = (opcode == OP_LOAD) ? ST_MEM_READ : ST_MEM_WRITE;
      end

      ST_MEM_READ: begin
        MemRead  = 1'b1;
        cnt_load = 1'b1;
        if (MEM_WAIT == 0) begin
          LoadMDR = 1'b1;
          state_d = ST_WB_LOAD;
        end else begin
          state_d = ST_MEM_WAIT_S;
        end
      end

      ST_MEM_WAIT_S: begin
        MemRead = 1'b1;
        if (cnt_done) begin
          LoadMDR = 1'b1;
          state_d = ST_WB_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      ST_WB_LOAD: begin
        RegWrite = 1'b1;
        MemToReg = M2R_MDR;
        state_d  = ST_BUSCA;
      end

      ST_MEM_WRITE: begin
        MemWrite = 1'b1;
        state_d  = ST_BUSCA;
      end

      // An unsupported funct3 must not redirect the PC; the unit halts instead.
      ST_BRANCH: begin
        ALUSrcA  = SRCA_A;
        ALUSrcB  = SRCB_B;
        ALUOp    = ALUOP_SUB;
        PCSource = PCSRC_ALUOUT;
        BranchNe = funct3[0];
        if (branch_f3_ok(funct3)) begin
          PCWriteCond = 1'b1;
          state_d     = ST_BUSCA;
        end else begin
          state_d     = ST_ERRO;
        end
      end

      // PC already holds PC+4 from BUSCA, which is the link value for rd.
      ST_JAL: begin
        RegWrite = 1'b1;
        MemToReg = M2R_PC;
        PCWrite  = 1'b1;
        PCSource = PCSRC_ALUOUT;
        state_d  = ST_BUSCA;
      end

      ST_ERRO: begin
        erro    = 1'b1;
        state_d = ST_ERRO;
      end

      default: state_d = ST_ERRO;
    endcase
  end

  assign estado = state_q;

endmodule

// File: tb/tb_uc_multiciclo.sv
module tb_uc_multiciclo;

  typedef struct packed {
    logic [6:0] estado;
    logic       pcw, pcwc, bne, lir, lpco, mrd, mwr, lmdr, lab, lalu, rw;
    logic [1:0] sa, sb, aop, pcs, m2r;
    logic       erro;
  } obs_t;

  localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3, K_BR = 4, K_JAL = 5,
                 K_ILL = 6, K_BADBR = 7;

  logic clock;
  logic rst_a, rst_b;
  logic [6:0] opc_a, opc_b;
  logic [2:0] f3_a, f3_b;
  logic zero_a, zero_b;

  logic [6:0] est_a, est_b;
  logic pcw_a, pcwc_a, bne_a, lir_a, lpco_a, mrd_a, mwr_a, lmdr_a, lab_a, lalu_a, rw_a, erro_a;
  logic pcw_b, pcwc_b, bne_b, lir_b, lpco_b, mrd_b, mwr_b, lmdr_b, lab_b, lalu_b, rw_b, erro_b;
  logic [1:0] sa_a, sb_a, aop_a, pcs_a, m2r_a;
  logic [1:0] sa_b, sb_b, aop_b, pcs_b, m2r_b;

  obs_t obs_a, obs_b;
  obs_t qa[$];
  obs_t qb[$];

  int checks = 0;
  int fails  = 0;

  // u_w2: MEM_WAIT=2 (driven as dut 2); u_w0: MEM_WAIT=0 (driven as dut 0)
  uc_multiciclo #(.MEM_WAIT(2)) u_w2 (
    .clock(clock), .reset(rst_a), .opcode(opc_a), .funct3(f3_a), .zero(zero_a),
    .estado(est_a), .PCWrite(pcw_a), .PCWriteCond(pcwc_a), .BranchNe(bne_a),
    .LoadIR(lir_a), .LoadPCold(lpco_a), .MemRead(mrd_a), .MemWrite(mwr_a),
    .LoadMDR(lmdr_a), .LoadAB(lab_a), .LoadALUOut(lalu_a), .RegWrite(rw_a),
    .ALUSrcA(sa_a), .ALUSrcB(sb_a), .ALUOp(aop_a), .PCSource(pcs_a),
    .MemToReg(m2r_a), .erro(erro_a)
  );

  uc_multiciclo #(.MEM_WAIT(0)) u_w0 (
    .clock(clock), .reset(rst_b), .opcode(opc_b), .funct3(f3_b), .zero(zero_b),
    .estado(est_b), .PCWrite(pcw_b), .PCWriteCond(pcwc_b), .BranchNe(bne_b),
    .LoadIR(lir_b), .LoadPCold(lpco_b), .MemRead(mrd_b), .MemWrite(mwr_b),
    .LoadMDR(lmdr_b), .LoadAB(lab_b), .LoadALUOut(lalu_b), .RegWrite(rw_b),
    .ALUSrcA(sa_b), .ALUSrcB(sb_b), .ALUOp(aop_b), .PCSource(pcs_b),
    .MemToReg(m2r_b), .erro(erro_b)
  );

  assign obs_a = {est_a, pcw_a, pcwc_a, bne_a, lir_a, lpco_a, mrd_a, mwr_a, lmdr_a, lab_a,
                  lalu_a, rw_a, sa_a, sb_a, aop_a, pcs_a, m2r_a, erro_a};
  assign obs_b = {est_b, pcw_b, pcwc_b, bne_b, lir_b, lpco_b, mrd_b, mwr_b, lmdr_b, lab_b,
                  lalu_b, rw_b, sa_b, sb_b, aop_b, pcs_b, m2r_b, erro_b};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at time %0t, limit 200000", $time);
    $fatal(1);
  end

  // Output table: what each state number must drive, straight from the state list.
  function automatic obs_t model(input int st, input logic [2:0] f3, input bit mdr);
    obs_t o;
    o = '0;
    o.estado = 7'(st);
    case (st)
      1:  begin o.lpco = 1; o.pcw = 1; o.sb = 2'd1; end
      2:  o.lir = 1;
      3:  begin o.lab = 1; o.lalu = 1; o.sa = 2'd2; o.sb = 2'd2; end
      4:  begin o.sa = 2'd1; o.aop = 2'd2; o.lalu = 1; end
      5:  begin o.sa = 2'd1; o.sb = 2'd2; o.aop = 2'd2; o.lalu = 1; end
      6:  o.rw = 1;
      7:  begin o.sa = 2'd1; o.sb = 2'd2; o.lalu = 1; end
      8, 9: begin o.mrd = 1; o.lmdr = mdr; end
      10: begin o.rw = 1; o.m2r = 2'd1; end
      11: o.mwr = 1;
      12: begin
        o.sa = 2'd1; o.aop = 2'd1; o.pcs = 2'd1; o.bne = f3[0];
        o.pcwc = (f3 == 3'b000) || (f3 == 3'b001);
      end
      13: begin o.rw = 1; o.m2r = 2'd2; o.pcw = 1; o.pcs = 2'd1; end
      127: o.erro = 1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic chk(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got estado=%0d ctl=%h, expected estado=%0d ctl=%h (t=%0t)",
               name, got.estado, got, exp.estado, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic push(input int d, input obs_t r);
    if (d == 2) qa.push_back(r);
    else        qb.push_back(r);
  endtask

  // Called #1 after the rising edge that entered BUSCA; returns #1 after the
  // edge that enters the next BUSCA (or after the requested ERRO cycles).
  task automatic issue(input int d, input int kind, input logic [2:0] f3, input logic z,
                       input int n_err, output int len);
    int w;
    obs_t tr[$];
    logic [6:0] op;
    logic [6:0] ill_ops[4];
    ill_ops = '{7'b0000000, 7'b1111111, 7'b0110111, 7'b0010111};
    w = (d == 2) ? 2 : 0;
    case (kind)
      K_R:     op = 7'b0110011;
      K_I:     op = 7'b0010011;
      K_LOAD:  op = 7'b0000011;
      K_STORE: op = 7'b0100011;
      K_JAL:   op = 7'b1101111;
      K_ILL:   op = ill_ops[$urandom_range(0, 3)];
      default: op = 7'b1100011;
    endcase
    tr.push_back(model(1, f3, 0));
    tr.push_back(model(2, f3, 0));
    tr.push_back(model(3, f3, 0));
    case (kind)
      K_R:     begin tr.push_back(model(4, f3, 0)); tr.push_back(model(6, f3, 0)); end
      K_I:     begin tr.push_back(model(5, f3, 0)); tr.push_back(model(6, f3, 0)); end
      K_LOAD: begin
        tr.push_back(model(7, f3, 0));
        tr.push_back(model(8, f3, w == 0));
        for (int i = 0; i < w; i++) tr.push_back(model(9, f3, i == w - 1));
        tr.push_back(model(10, f3, 0));
      end
      K_STORE: begin tr.push_back(model(7, f3, 0)); tr.push_back(model(11, f3, 0)); end
      K_BR:    tr.push_back(model(12, f3, 0));
      K_JAL:   tr.push_back(model(13, f3, 0));
      K_ILL:   for (int i = 0; i < n_err; i++) tr.push_back(model(127, f3, 0));
      default: begin
        tr.push_back(model(12, f3, 0));
        for (int i = 0; i < n_err; i++) tr.push_back(model(127, f3, 0));
      end
    endcase
    len = tr.size();
    if (d == 2) begin opc_a = op; f3_a = f3; zero_a = z; end
    else        begin opc_b = op; f3_b = f3; zero_b = z; end
    foreach (tr[i]) push(d, tr[i]);
    repeat (len) @(posedge clock);
    #1;
  endtask

  // Called #1 after a rising edge; reset is asserted between edges and must act at once.
  task automatic do_reset(input int d, input int n);
    if (d == 2) rst_a = 1'b0;
    else        rst_b = 1'b0;
    #1;
    chk((d == 2) ? "async reset w2" : "async reset w0", (d == 2) ? obs_a : obs_b,
        model(0, 3'b000, 0));
    push(d, model(0, 3'b000, 0));
    repeat (n) begin
      @(posedge clock);
      #1;
      push(d, model(0, 3'b000, 0));
    end
    if (d == 2) rst_a = 1'b1;
    else        rst_b = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic random_run(input int d, input int n);
    int k, len;
    logic [2:0] f3;
    for (int i = 0; i < n; i++) begin
      k  = $urandom_range(0, 5);
      f3 = (k == K_BR) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
      issue(d, k, f3, 1'($urandom_range(0, 1)), 0, len);
    end
  endtask

  // Single compare process: one expected record per cycle, sampled on the falling edge.
  always @(negedge clock) begin
    obs_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("cycle w2", obs_a, e);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("cycle w0", obs_b, e);
    end
    chk_int("w2 MemRead&MemWrite", int'(mrd_a & mwr_a), 0);
    chk_int("w2 RegWrite&PCWriteCond", int'(rw_a & pcwc_a), 0);
    chk_int("w0 MemRead&MemWrite", int'(mrd_b & mwr_b), 0);
    chk_int("w0 RegWrite&PCWriteCond", int'(rw_b & pcwc_b), 0);
  end

  initial begin
    int len;
    rst_a = 1'b0; rst_b = 1'b0;
    opc_a = 7'b0110011; f3_a = 3'b000; zero_a = 1'b0;
    opc_b = 7'b0110011; f3_b = 3'b000; zero_b = 1'b0;
    #1;
    chk("reset state w2", obs_a, model(0, 3'b000, 0));
    chk("reset state w0", obs_b, model(0, 3'b000, 0));
    @(posedge clock);
    #1;

    // ---- MEM_WAIT = 2 instance ----
    do_reset(2, 3);
    issue(2, K_R, 3'b000, 1'b0, 0, len);     chk_int("R latency", len, 5);
    issue(2, K_LOAD, 3'b010, 1'b0, 0, len);  chk_int("load latency w2", len, 8);
    issue(2, K_BR, 3'b001, 1'b0, 0, len);    chk_int("BNE latency", len, 4);
    issue(2, K_BR, 3'b000, 1'b1, 0, len);    chk_int("BEQ latency", len, 4);
    issue(2, K_STORE, 3'b010, 1'b0, 0, len); chk_int("store latency", len, 5);
    issue(2, K_JAL, 3'b000, 1'b0, 0, len);   chk_int("JAL latency", len, 4);
    issue(2, K_I, 3'b111, 1'b0, 0, len);     chk_int("I latency", len, 5);
    random_run(2, 40);

    // Reset asserted between edges while the load sits in the memory wait.
    opc_a = 7'b0000011; f3_a = 3'b010;
    push(2, model(1, 3'b010, 0)); push(2, model(2, 3'b010, 0));
    push(2, model(3, 3'b010, 0)); push(2, model(7, 3'b010, 0));
    push(2, model(8, 3'b010, 0)); push(2, model(9, 3'b010, 0));
    repeat (5) @(posedge clock);
    #6;
    rst_a = 1'b0;
    #1;
    chk_int("mid-wait reset estado", int'(est_a), 0);
    chk("mid-wait reset outputs", obs_a, model(0, 3'b000, 0));
    @(posedge clock);
    #1;
    push(2, model(0, 3'b000, 0));
    rst_a = 1'b1;
    @(posedge clock);
    #1;
    issue(2, K_LOAD, 3'b010, 1'b0, 0, len);
    issue(2, K_R, 3'b000, 1'b0, 0, len);

    // Unsupported branch funct3 halts; erro must persist until reset.
    issue(2, K_BADBR, 3'b011, 1'b0, 20, len); chk_int("bad branch trace", len, 24);
    do_reset(2, 1);
    issue(2, K_R, 3'b000, 1'b0, 0, len);
    issue(2, K_ILL, 3'b000, 1'b0, 5, len);
    do_reset(2, 1);

    // ---- MEM_WAIT = 0 instance ----
    do_reset(0, 1);
    issue(0, K_STORE, 3'b010, 1'b0, 0, len);
    issue(0, K_LOAD, 3'b010, 1'b0, 0, len);  chk_int("load latency w0", len, 6);
    random_run(0, 30);
    issue(0, K_ILL, 3'b000, 1'b0, 3, len);
    do_reset(0, 1);

    repeat (2) @(posedge clock);
    #1;
    chk_int("expected queues drained", qa.size() + qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
